// File: rtl/regs_wb_sched_pkg.sv
// regs_wb_sched_pkg: shared register-file widths, requester ids and arbiter helpers.
package regs_wb_sched_pkg;
  localparam int RegBus = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum = 32;
  localparam int RegNumLog2 = 5;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic RstEnable = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic [1:0] WbReqAlu = 2'd0;
  localparam logic [1:0] WbReqMd = 2'd1;
  localparam logic [1:0] WbReqLsu = 2'd2;
  localparam int WbNumReq = 3;
  function automatic logic [WbNumReq-1:0] wb_onehot(input logic [1:0] i);
    return WbNumReq'(1) << i;
  endfunction
endpackage

// File: rtl/regs_wb_sched_arb3.sv
// wb_rr_arb3: 3-way round-robin arbiter; the pointer remembers the last granted requester.
module wb_rr_arb3
  import regs_wb_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [WbNumReq-1:0] req,
  input  logic                advance,
  output logic [WbNumReq-1:0] grant
);
  logic [1:0] ptr, p0, p1;
  always_comb begin
    p0 = (ptr == WbReqLsu) ? WbReqAlu : ptr + 2'd1;
    p1 = (p0 == WbReqLsu) ? WbReqAlu : p0 + 2'd1;
    grant = (rst == RstEnable) ? '0 :
            req[p0]  ? wb_onehot(p0) :
            req[p1]  ? wb_onehot(p1) :
            req[ptr] ? wb_onehot(ptr) : '0;
  end
  always_ff @(posedge clk)
    if (rst == RstEnable) ptr <= WbReqLsu;
    else if (advance) ptr <= grant[0] ? WbReqAlu : grant[1] ? WbReqMd : WbReqLsu;
endmodule

// File: rtl/regs_wb_sched.sv
// regs_wb_sched: arbitrates ALU/MULDIV/LSU onto the register-file write port and tracks in-flight long-latency writes.
module regs_wb_sched
  import regs_wb_sched_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus,
  parameter int NREG = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_waddr_i,
  input  logic [DATA_W-1:0] alu_wdata_i,
  output logic              alu_ready_o,
  input  logic              md_valid_i,
  input  logic [ADDR_W-1:0] md_waddr_i,
  input  logic [DATA_W-1:0] md_wdata_i,
  output logic              md_ready_o,
  input  logic              lsu_valid_i,
  input  logic [ADDR_W-1:0] lsu_waddr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic              lsu_ready_o,
  input  logic              sb_set_i,
  input  logic [ADDR_W-1:0] sb_set_addr_i,
  input  logic              chk_re1_i,
  input  logic              chk_re2_i,
  input  logic              chk_rde_i,
  input  logic [ADDR_W-1:0] chk_raddr1_i,
  input  logic [ADDR_W-1:0] chk_raddr2_i,
  input  logic [ADDR_W-1:0] chk_rd_i,
  output logic              hazard_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o
);
  logic [WbNumReq-1:0] grant;
  logic                xfer;
  logic [ADDR_W-1:0]   sel_waddr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [NREG-1:0]     busy, clr_m, set_m;
  wb_rr_arb3 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({lsu_valid_i, md_valid_i, alu_valid_i}),
    .advance (xfer),
    .grant   (grant)
  );
  always_comb begin
    {lsu_ready_o, md_ready_o, alu_ready_o} = grant;
    xfer = |grant;
    sel_waddr = grant[0] ? alu_waddr_i : grant[1] ? md_waddr_i : lsu_waddr_i;
    sel_wdata = grant[0] ? alu_wdata_i : grant[1] ? md_wdata_i : lsu_wdata_i;
    clr_m = (grant[1] | grant[2]) ? NREG'(1) << sel_waddr : '0;
    set_m = sb_set_i ? NREG'(1) << sb_set_addr_i : '0;
    hazard_o = (rst != RstEnable) & ((chk_re1_i & busy[chk_raddr1_i]) |
                                     (chk_re2_i & busy[chk_raddr2_i]) |
                                     (chk_rde_i & busy[chk_rd_i]));
  end
  // Set is OR-ed after the clear so a same-edge issue keeps the register busy; bit 0 is masked for x0.
  always_ff @(posedge clk)
    if (rst == RstEnable) begin
      we_o <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
      busy <= '0;
    end else begin
      we_o <= xfer && sel_waddr != '0;
      if (xfer) begin
        waddr_o <= sel_waddr;
        wdata_o <= sel_wdata;
      end
      busy <= ((busy & ~clr_m) | set_m) & ~NREG'(1);
    end
endmodule

// File: tb/tb_regs_wb_sched.sv
// tb_regs_wb_sched: directed vectors with hand-computed expectations for regs_wb_sched.
module tb_regs_wb_sched;
  logic clk = 0, rst;
  logic alu_valid_i, md_valid_i, lsu_valid_i;
  logic [4:0] alu_waddr_i, md_waddr_i, lsu_waddr_i;
  logic [31:0] alu_wdata_i, md_wdata_i, lsu_wdata_i;
  logic alu_ready_o, md_ready_o, lsu_ready_o;
  logic sb_set_i, chk_re1_i, chk_re2_i, chk_rde_i;
  logic [4:0] sb_set_addr_i, chk_raddr1_i, chk_raddr2_i, chk_rd_i;
  logic hazard_o, we_o;
  logic [4:0] waddr_o;
  logic [31:0] wdata_o;
  int checks = 0, errors = 0;

  regs_wb_sched dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i), .alu_ready_o(alu_ready_o),
    .md_valid_i(md_valid_i), .md_waddr_i(md_waddr_i), .md_wdata_i(md_wdata_i), .md_ready_o(md_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_ready_o(lsu_ready_o),
    .sb_set_i(sb_set_i), .sb_set_addr_i(sb_set_addr_i),
    .chk_re1_i(chk_re1_i), .chk_re2_i(chk_re2_i), .chk_rde_i(chk_rde_i),
    .chk_raddr1_i(chk_raddr1_i), .chk_raddr2_i(chk_raddr2_i), .chk_rd_i(chk_rd_i),
    .hazard_o(hazard_o), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rdy(input string tag, input logic [2:0] exp);
    #1 check(tag, {29'd0, lsu_ready_o, md_ready_o, alu_ready_o}, {29'd0, exp});
  endtask

  initial begin
    rst = 1;
    {alu_valid_i, md_valid_i, lsu_valid_i} = 3'b111;
    alu_waddr_i = 1; md_waddr_i = 2; lsu_waddr_i = 3;
    alu_wdata_i = 32'h11; md_wdata_i = 32'h22; lsu_wdata_i = 32'h33;
    sb_set_i = 0; sb_set_addr_i = 0;
    chk_re1_i = 1; chk_re2_i = 0; chk_rde_i = 0;
    chk_raddr1_i = 0; chk_raddr2_i = 0; chk_rd_i = 0;
    tick;
    tick;
    rdy("rst_ready", 3'b000);
    check("rst_we", {31'd0, we_o}, 0);
    check("rst_waddr", {27'd0, waddr_o}, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_hazard", {31'd0, hazard_o}, 0);
    chk_re1_i = 0;
    // contention: ALU first after reset, then MD, LSU, ALU
    rst = 0;
    rdy("rr_g0", 3'b001);
    tick;
    check("rr_w0", {26'd0, we_o, waddr_o}, {26'd0, 1'b1, 5'd1});
    check("rr_d0", wdata_o, 32'h11);
    rdy("rr_g1", 3'b010);
    tick;
    check("rr_w1", {26'd0, we_o, waddr_o}, {26'd0, 1'b1, 5'd2});
    check("rr_d1", wdata_o, 32'h22);
    rdy("rr_g2", 3'b100);
    tick;
    check("rr_w2", {26'd0, we_o, waddr_o}, {26'd0, 1'b1, 5'd3});
    rdy("rr_g3", 3'b001);
    tick;
    check("rr_w3", {26'd0, we_o, waddr_o}, {26'd0, 1'b1, 5'd1});
    {alu_valid_i, md_valid_i, lsu_valid_i} = 3'b000;
    tick;
    check("idle_we", {31'd0, we_o}, 0);
    check("idle_hold", {27'd0, waddr_o}, 1);
    // single ALU write
    alu_valid_i = 1; alu_waddr_i = 5; alu_wdata_i = 32'hDEADBEEF;
    rdy("alu_ready", 3'b001);
    tick;
    alu_valid_i = 0;
    check("alu_we", {31'd0, we_o}, 1);
    check("alu_waddr", {27'd0, waddr_o}, 5);
    check("alu_wdata", wdata_o, 32'hDEADBEEF);
    tick;
    check("alu_we_off", {31'd0, we_o}, 0);
    check("alu_hold", wdata_o, 32'hDEADBEEF);
    // scoreboard set/clear on x7, plus x0 never becoming busy
    sb_set_i = 1; sb_set_addr_i = 7;
    tick;
    sb_set_addr_i = 0;
    tick;
    sb_set_i = 0;
    chk_re1_i = 1; chk_raddr1_i = 0;
    #1 check("x0_busy", {31'd0, hazard_o}, 0);
    chk_raddr1_i = 7;
    #1 check("sb_rs1", {31'd0, hazard_o}, 1);
    chk_re1_i = 0;
    #1 check("sb_noen", {31'd0, hazard_o}, 0);
    chk_re2_i = 1; chk_raddr2_i = 7;
    #1 check("sb_rs2", {31'd0, hazard_o}, 1);
    chk_re2_i = 0; chk_rde_i = 1; chk_rd_i = 7;
    #1 check("sb_rd", {31'd0, hazard_o}, 1);
    chk_rde_i = 0; chk_re1_i = 1;
    md_valid_i = 1; md_waddr_i = 7; md_wdata_i = 32'h77;
    rdy("md_ready", 3'b010);
    check("sb_pre_clr", {31'd0, hazard_o}, 1);
    tick;
    md_valid_i = 0;
    check("sb_clr", {31'd0, hazard_o}, 0);
    check("md_we", {26'd0, we_o, waddr_o}, {26'd0, 1'b1, 5'd7});
    check("md_wdata", wdata_o, 32'h77);
    // same-edge set and clear of x9: set wins
    lsu_valid_i = 1; lsu_waddr_i = 9; lsu_wdata_i = 32'h99;
    sb_set_i = 1; sb_set_addr_i = 9;
    chk_raddr1_i = 9;
    rdy("col_ready", 3'b100);
    tick;
    sb_set_i = 0;
    #1 check("col_busy", {31'd0, hazard_o}, 1);
    check("col_we", {26'd0, we_o, waddr_o}, {26'd0, 1'b1, 5'd9});
    tick;
    lsu_valid_i = 0;
    check("lsu_clr", {31'd0, hazard_o}, 0);
    // ALU writes never clear busy
    sb_set_i = 1; sb_set_addr_i = 10;
    tick;
    sb_set_i = 0;
    alu_valid_i = 1; alu_waddr_i = 10; alu_wdata_i = 32'hA;
    chk_raddr1_i = 10;
    rdy("alu10_ready", 3'b001);
    tick;
    alu_valid_i = 0;
    check("alu_noclr", {31'd0, hazard_o}, 1);
    md_valid_i = 1; md_waddr_i = 10;
    tick;
    md_valid_i = 0;
    check("md10_clr", {31'd0, hazard_o}, 0);
    // x0 request consumed without a write
    lsu_valid_i = 1; lsu_waddr_i = 0; lsu_wdata_i = 32'h55;
    rdy("x0_ready", 3'b100);
    tick;
    lsu_valid_i = 0;
    check("x0_we", {31'd0, we_o}, 0);
    // reset mid-operation
    sb_set_i = 1; sb_set_addr_i = 4;
    tick;
    sb_set_i = 0;
    chk_raddr1_i = 4;
    #1 check("b4_set", {31'd0, hazard_o}, 1);
    md_valid_i = 1; md_waddr_i = 4; md_wdata_i = 32'h44;
    rst = 1;
    rdy("rst_md_ready", 3'b000);
    check("rst_hz", {31'd0, hazard_o}, 0);
    tick;
    check("rst2_we", {31'd0, we_o}, 0);
    rst = 0; md_valid_i = 0;
    #1 check("rst_busy_clr", {31'd0, hazard_o}, 0);
    tick;
    check("rst_nowrite", {31'd0, we_o}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regs_wb_sched.md
Name: regs_wb_sched

Overview:
- Writeback scheduler and scoreboard for the single-write-port 32x32 integer register file of the RV32IM core.
- Round-robin arbitration shares the write port between three producers: the ALU (single-cycle), the MUL/DIV unit (multi-cycle) and the LSU (loads).
- Tracks registers with long-latency writes in flight and raises a decode-stage hazard.
- Sits between the execute/memory units and the register file; drives the file's we/waddr/wdata inputs directly.

Parameters:
- DATA_W, 32, register data width (RegBus).
- ADDR_W, 5, register address width (RegAddrBus).
- NREG, 32, number of architectural registers; must equal 2^ADDR_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_valid_i  in  1  ALU writeback request
- alu_waddr_i  in  ADDR_W  ALU destination register
- alu_wdata_i  in  DATA_W  ALU result
- alu_ready_o  out  1  ALU request granted this cycle
- md_valid_i / md_waddr_i / md_wdata_i / md_ready_o  same shape as the ALU group, for MUL/DIV
- lsu_valid_i / lsu_waddr_i / lsu_wdata_i / lsu_ready_o  same shape as the ALU group, for LSU load data
- sb_set_i  in  1  decode issues a MUL/DIV or load; mark destination busy
- sb_set_addr_i  in  ADDR_W  destination of that issue
- chk_re1_i, chk_re2_i, chk_rde_i  in  1 each  check enables for rs1, rs2, rd
- chk_raddr1_i, chk_raddr2_i, chk_rd_i  in  ADDR_W each  addresses being checked
- hazard_o  out  1  decode must stall
- we_o  out  1  register file write enable
- waddr_o  out  ADDR_W  register file write address
- wdata_o  out  DATA_W  register file write data

Behaviour:
- Reset (rst=1 at a clk edge):
  - we_o=0, waddr_o=0, wdata_o=0.
  - busy vector = 0.
  - RR pointer = LSU, so the ALU has first priority after reset.
  - All ready_o=0 and hazard_o=0 for as long as rst=1. Transfers pending when reset hits are dropped.
- Handshake: transfer = valid & ready on a requester in the same cycle.
  - A requester holds valid, waddr and wdata stable until ready.
  - ready_o is combinational from the valid inputs and the RR pointer.
  - At most one ready_o is high per cycle.
- Arbitration: round-robin.
  - Search order starts at the requester after the last granted one (ALU -> MD -> LSU -> ALU).
  - The pointer updates only on a transfer.
  - Any continuously valid requester is granted within 3 cycles.
- Latency: 1 cycle. The transfer at edge N loads we_o=1, waddr_o, wdata_o, visible in cycle N+1.
  - With no transfer, we_o=0 and waddr_o/wdata_o hold their values.
  - Sustained throughput is 1 write per cycle with no bubbles.
- Writes to x0: the request is granted and consumed, but we_o stays 0. The busy vector is untouched.
- Scoreboard:
  - busy[NREG-1:0]; busy[0] is hardwired to 0.
  - Set: sb_set_i=1 with a nonzero address sets busy[addr] at the edge.
  - Clear: a transfer from MD or LSU clears busy[waddr] at the same edge that loads the output register. The register file's write-port bypass covers the following cycle.
  - ALU transfers never clear busy.
  - Same-edge set and clear of the same address: set wins.
- Hazard, combinational:
  - hazard_o = (chk_re1_i & busy[chk_raddr1_i]) | (chk_re2_i & busy[chk_raddr2_i]) | (chk_rde_i & busy[chk_rd_i]).
  - The rd check prevents WAW reordering and double-set.
  - Decode must not assert sb_set_i while hazard_o=1.

Decomposition:
- Shared package/defines (existing defines.v): RegBus, RegAddrBus, RegNum, RegNumLog2, ZeroWord, RstEnable, WriteEnable. Add WbReqAlu=2'd0, WbReqMd=2'd1, WbReqLsu=2'd2, WbNumReq=3.
- One sub-module, wb_rr_arb3: a 3-way round-robin arbiter (req[2:0] in, grant[2:0] out, pointer register inside, advance input).
- Scoreboard and output register stay in the top level.

Test Plan:
- Reset then idle: drive rst=1 for 2 cycles with all valid inputs=1 -> all ready_o=0, we_o=0, hazard_o=0; after release, ALU is granted first.
- Single ALU write: alu_valid=1, waddr=5, wdata=0xDEADBEEF -> alu_ready=1 the same cycle; next cycle we_o=1, waddr_o=5, wdata_o=0xDEADBEEF; the cycle after, we_o=0.
- Contention: all three valid continuously, addrs 1/2/3 -> grant order ALU, MD, LSU, ALU; the output waddr sequence is 1,2,3,1 on consecutive cycles.
- Scoreboard: sb_set addr=7, then chk_re1 with raddr1=7 -> hazard_o=1 until an MD transfer to x7 at edge N; hazard_o=0 from cycle N+1, while we_o=1 with waddr_o=7.
- Set/clear collision: LSU transfer to x9 and sb_set addr=9 at the same edge -> busy[9] remains 1 and hazard_o=1 on a check of x9.
- x0 and reset mid-op: LSU request to x0 -> lsu_ready=1, we_o stays 0; then assert rst with busy[4]=1 and md_valid high -> busy cleared, md_ready=0, we_o=0.
